mac_top: RTL and testbench
==========================

Name: mac_top

Overview:
- Top level of a small multiply-accumulate engine built around one shared 8x8-input MAC datapath (out = in1*in2 + in_add) and a control FSM.
- Two operating modes, selected per job by `mode`:
  - Trinomial evaluation, mode=1: y = (a*x + b)*x + c.
  - Sum-of-products accumulation, mode=0: y = Σ a_i*x_i over a sequence terminated by `last_input`.
- Sits between an upstream operand source using a valid/last strobe and a downstream consumer of a 17-bit result with a valid pulse.

Parameters:
- DW, 8, operand width of a, b, c, x.
- OW, 17, result/accumulator width; all arithmetic is modulo 2^OW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_input  in  1  operands and mode are valid this cycle.
- last_input  in  1  qualifies valid_input; marks the final term of a sum-of-products sequence (ignored in mode 1).
- mode  in  1  1 = trinomial, 0 = sum-of-products; sampled with valid_input.
- num_a  in  DW  coefficient a (unsigned).
- num_b  in  DW  coefficient b (unsigned, mode 1 only).
- num_c  in  DW  coefficient c (unsigned, mode 1 only).
- num_x  in  DW  variable x (unsigned).
- valid_output  out  1  single-cycle pulse: final_output carries a new result.
- final_output  out  OW  result; holds its last value between pulses.

Behaviour:
- Reset (async, active high): state=IDLE; accumulator, stage register, latched x/c, final_output and valid_output all cleared to 0.
- Arithmetic:
  - All operands are unsigned.
  - MAC computes in1(OW)*in2(DW) + in_add(OW), truncated to OW bits (wrap, no saturation, no overflow flag).
- FSM states: IDLE, TRI2, SUMP_ACC. valid_output defaults to 0 every cycle unless set below.
- IDLE with valid_input & mode=1:
  - Latch x and c.
  - stage <= a*x + b.
  - Go to TRI2.
- TRI2:
  - final_output <= stage*x_lat + c_lat.
  - valid_output <= 1.
  - Go to IDLE.
  - All inputs are ignored in this state.
  - Trinomial latency: result and valid appear 2 clocks after the accepting edge.
- IDLE or SUMP_ACC with valid_input & mode=0:
  - sum = a*x + acc.
  - If last_input: final_output <= sum, valid_output <= 1, acc <= 0, go to IDLE (latency 1 clock).
  - Otherwise: acc <= sum, go to SUMP_ACC.
- SUMP_ACC with valid_input & mode=1: input dropped; accumulation continues undisturbed.
- SUMP_ACC with no valid_input: hold state and acc indefinitely (gaps allowed).
- valid_input=0: last_input and the operands are don't-care.
- Back-to-back operation:
  - Trinomial jobs accepted at most every 2 clocks.
  - Sum-of-products terms accepted every clock, including a new sequence in the cycle right after a last term.
- Reset mid-operation: any in-flight job is discarded and no valid_output is produced for it.

Decomposition:
- Shared package mac_pkg: DW, OW, state enum {IDLE, TRI2, SUMP_ACC}, MODE_TRI=1, MODE_SUMP=0.
- One sub-module mac_unit: purely combinational in1*in2+in_add, OW-bit truncated. Used for both trinomial passes and accumulation via input muxes.
- The FSM and registers live in mac_top.

Test Plan:
- Trinomial a=5, x=3, b=2, c=1, mode=1, one-cycle valid -> 2 clocks later valid_output pulse with final_output=52; IDLE afterwards.
- Trinomial a=9, x=8, b=7, c=6 -> 638. Then a=b=c=x=255 -> 511, i.e. (65280*255+255) mod 2^17, checking wrap.
- Sum-of-products, mode=0:
  - (5,3) without last, then (9,8) with last -> one pulse, 1 clock after the second term, final_output=87.
  - Next sequence with single term (2,4)+last -> 8, confirming the accumulator cleared.
  - Three terms of (255,255), last on the third -> 64003 (195075 mod 2^17). Idle gap cycles between terms give the same result.
- Ignored inputs:
  - A mode=1 valid during TRI2 produces no extra result.
  - A mode=1 valid during SUMP_ACC is dropped, and the sum continues correctly.
- Reset asserted while in TRI2 or SUMP_ACC -> outputs 0, no pulse. A subsequent trinomial 5,3,2,1 still yields 52.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and types for the multiply-accumulate engine.
// Operand/result widths, FSM state encoding and mode selector values.
// Imported by mac_unit and mac_top.
package mac_pkg;

   localparam int DW = 8;    // operand width of a, b, c, x
   localparam int OW = 17;   // result / accumulator width, arithmetic mod 2^OW

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRI2     = 2'd1,
      SUMP_ACC = 2'd2
   } state_t;

   localparam logic MODE_TRI  = 1'b1;
   localparam logic MODE_SUMP = 1'b0;

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-add: o_out = i_in1 * i_in2 + i_add, truncated to OW bits.
// Latency: zero (pure combinational).
// Backpressure: none; output follows inputs.
module mac_unit
   import mac_pkg::*;
(
   input  logic [OW-1:0] i_in1,
   input  logic [DW-1:0] i_in2,
   input  logic [OW-1:0] i_add,
   output logic [OW-1:0] o_out
);

   // Only the low OW bits of the product survive, so the multiply is done
   // directly at OW width; the bits it discards never reach the result.
   logic [OW-1:0] w_prod;

   assign w_prod = i_in1 * {{(OW-DW){1'b0}}, i_in2};
   assign o_out  = w_prod + i_add;

endmodule

// File: rtl/mac_top.sv
// MAC engine: trinomial (a*x+b)*x+c or sum-of-products over a last-terminated sequence.
// Latency: trinomial result 2 clocks after acceptance, sum-of-products 1 clock after last term.
// Backpressure: none; trinomial inputs are ignored during the second pass, mode-1 inputs dropped mid-sum.
module mac_top
   import mac_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_input,
   input  logic          last_input,
   input  logic          mode,
   input  logic [DW-1:0] num_a,
   input  logic [DW-1:0] num_b,
   input  logic [DW-1:0] num_c,
   input  logic [DW-1:0] num_x,
   output logic          valid_output,
   output logic [OW-1:0] final_output
);

   state_t        r_state;
   state_t        w_state_nxt;

   logic [OW-1:0] r_acc;
   logic [OW-1:0] r_stage;
   logic [DW-1:0] r_x_lat;
   logic [DW-1:0] r_c_lat;
   logic [OW-1:0] r_final;
   logic          r_valid;

   logic [OW-1:0] w_acc_nxt;
   logic [OW-1:0] w_stage_nxt;
   logic [DW-1:0] w_x_lat_nxt;
   logic [DW-1:0] w_c_lat_nxt;
   logic [OW-1:0] w_final_nxt;
   logic          w_valid_nxt;

   logic [OW-1:0] w_in1;
   logic [DW-1:0] w_in2;
   logic [OW-1:0] w_add;
   logic [OW-1:0] w_mac;

   logic          w_sop_take;

   // A sum-of-products term is accepted in IDLE or while already accumulating.
   assign w_sop_take = valid_input && (mode == MODE_SUMP) &&
                       ((r_state == IDLE) || (r_state == SUMP_ACC));

   // Shared datapath input muxing: TRI2 runs the second trinomial pass from the
   // latched operands; otherwise the live a*x is added to b (trinomial first
   // pass) or to the running accumulator (sum-of-products).
   always_comb begin
      w_in1 = {{(OW-DW){1'b0}}, num_a};
      w_in2 = num_x;
      w_add = r_acc;
      if (r_state == TRI2) begin
         w_in1 = r_stage;
         w_in2 = r_x_lat;
         w_add = {{(OW-DW){1'b0}}, r_c_lat};
      end else if (mode == MODE_TRI) begin
         w_add = {{(OW-DW){1'b0}}, num_b};
      end
   end

   mac_unit u_mac_unit (
      .i_in1 (w_in1),
      .i_in2 (w_in2),
      .i_add (w_add),
      .o_out (w_mac)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-register values; valid pulse defaults low every cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_stage_nxt = r_stage;
      w_x_lat_nxt = r_x_lat;
      w_c_lat_nxt = r_c_lat;
      w_final_nxt = r_final;
      w_valid_nxt = 1'b0;

      case (r_state)
         IDLE: begin
            if (valid_input && (mode == MODE_TRI)) begin
               w_x_lat_nxt = num_x;
               w_c_lat_nxt = num_c;
               w_stage_nxt = w_mac;
               w_state_nxt = TRI2;
            end
         end
         TRI2: begin
            // Inputs are ignored here; the datapath is busy with the second pass.
            w_final_nxt = w_mac;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
         end
         SUMP_ACC: begin
            // Mode-1 valids fall through untouched: dropped, accumulator held.
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_sop_take) begin
         if (last_input) begin
            w_final_nxt = w_mac;
            w_valid_nxt = 1'b1;
            w_acc_nxt   = '0;
            w_state_nxt = IDLE;
         end else begin
            w_acc_nxt   = w_mac;
            w_state_nxt = SUMP_ACC;
         end
      end
   end

   // Datapath and output registers; reset discards any in-flight job.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc   <= '0;
         r_stage <= '0;
         r_x_lat <= '0;
         r_c_lat <= '0;
         r_final <= '0;
         r_valid <= 1'b0;
      end else begin
         r_acc   <= w_acc_nxt;
         r_stage <= w_stage_nxt;
         r_x_lat <= w_x_lat_nxt;
         r_c_lat <= w_c_lat_nxt;
         r_final <= w_final_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign valid_output = r_valid;
   assign final_output = r_final;

endmodule

// File: tb/tb_mac_top.sv
// Directed self-checking bench for mac_top.
// Drives operands after each rising edge, samples outputs 1 time unit after it.
// Expected values are hand-computed constants.
module tb_mac_top;
   import mac_pkg::*;

   logic          clk;
   logic          reset;
   logic          valid_input;
   logic          last_input;
   logic          mode;
   logic [DW-1:0] num_a;
   logic [DW-1:0] num_b;
   logic [DW-1:0] num_c;
   logic [DW-1:0] num_x;
   logic          valid_output;
   logic [OW-1:0] final_output;

   int n_tests = 0;
   int n_fail  = 0;

   mac_top dut (
      .clk          (clk),
      .reset        (reset),
      .valid_input  (valid_input),
      .last_input   (last_input),
      .mode         (mode),
      .num_a        (num_a),
      .num_b        (num_b),
      .num_c        (num_c),
      .num_x        (num_x),
      .valid_output (valid_output),
      .final_output (final_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic l, input logic m,
                        input int a, input int b, input int c, input int x);
      valid_input = v;
      last_input  = l;
      mode        = m;
      num_a       = a[DW-1:0];
      num_b       = b[DW-1:0];
      num_c       = c[DW-1:0];
      num_x       = x[DW-1:0];
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   // Advance one clock and settle past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the cycle carries a result pulse with the given value.
   task automatic expect_pulse(input string tag, input int val);
      check({tag, "_vld"}, {31'd0, valid_output}, 32'd1);
      check({tag, "_dat"}, {15'd0, final_output}, val);
   endtask

   task automatic expect_quiet(input string tag);
      check({tag, "_novld"}, {31'd0, valid_output}, 32'd0);
   endtask

   // Hard stop if the sequence somehow stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      #3;
      check("rst_vld", {31'd0, valid_output}, 32'd0);
      check("rst_dat", {15'd0, final_output}, 32'd0);
      step();
      step();
      reset = 1'b0;
      step();

      // Trinomial 5,3,2,1: (5*3+2)*3+1 = 52, pulse two clocks after drive.
      drive(1'b1, 1'b0, MODE_TRI, 5, 2, 1, 3);
      step();
      idle();
      expect_quiet("tri52_e0");
      step();
      expect_pulse("tri52", 52);
      step();
      expect_quiet("tri52_after");
      check("tri52_hold", {15'd0, final_output}, 32'd52);

      // Trinomial 9,8,7,6 -> 638; a mode-1 valid held into TRI2 is ignored.
      drive(1'b1, 1'b0, MODE_TRI, 9, 7, 6, 8);
      step();
      drive(1'b1, 1'b0, MODE_TRI, 1, 1, 1, 1);
      expect_quiet("tri638_e0");
      step();
      idle();
      expect_pulse("tri638", 638);
      step();
      expect_quiet("tri2_ignored");
      step();
      expect_quiet("tri2_ignored2");
      check("tri2_ignored_hold", {15'd0, final_output}, 32'd638);

      // All 255: (65280*255+255) mod 2^17 = 511.
      drive(1'b1, 1'b0, MODE_TRI, 255, 255, 255, 255);
      step();
      idle();
      step();
      expect_pulse("tri_wrap", 511);
      step();

      // Sum of products 5*3 + 9*8 = 87, then back-to-back single term 2*4 = 8.
      drive(1'b1, 1'b0, MODE_SUMP, 5, 0, 0, 3);
      step();
      expect_quiet("sop87_t1");
      drive(1'b1, 1'b1, MODE_SUMP, 9, 0, 0, 8);
      step();
      expect_pulse("sop87", 87);
      drive(1'b1, 1'b1, MODE_SUMP, 2, 0, 0, 4);
      step();
      idle();
      expect_pulse("sop8", 8);
      step();
      expect_quiet("sop8_after");

      // Three 255*255 terms back to back: 195075 mod 2^17 = 64003.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, (i == 2), MODE_SUMP, 255, 0, 0, 255);
         step();
      end
      idle();
      expect_pulse("sop_wrap", 64003);
      step();

      // Same three terms with idle gaps between them.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, (i == 2), MODE_SUMP, 255, 0, 0, 255);
         step();
         idle();
         if (i < 2) begin
            expect_quiet("sop_gap_term");
            step();
            step();
         end
      end
      expect_pulse("sop_gap", 64003);
      step();

      // Mode-1 valid mid-sum is dropped: 5*3 + 9*8 still 87.
      drive(1'b1, 1'b0, MODE_SUMP, 5, 0, 0, 3);
      step();
      drive(1'b1, 1'b0, MODE_TRI, 100, 50, 25, 7);
      step();
      expect_quiet("sop_drop_tri");
      drive(1'b1, 1'b1, MODE_SUMP, 9, 0, 0, 8);
      step();
      idle();
      expect_pulse("sop_drop", 87);
      step();
      expect_quiet("sop_drop_after");

      // Reset during TRI2: outputs clear, no pulse afterwards.
      drive(1'b1, 1'b0, MODE_TRI, 5, 2, 1, 3);
      step();
      idle();
      reset = 1'b1;
      #1;
      check("rst_tri2_vld", {31'd0, valid_output}, 32'd0);
      check("rst_tri2_dat", {15'd0, final_output}, 32'd0);
      step();
      reset = 1'b0;
      step();
      expect_quiet("rst_tri2_nopulse");
      check("rst_tri2_dat2", {15'd0, final_output}, 32'd0);

      // Reset during SUMP_ACC: partial sum discarded, next term starts fresh.
      drive(1'b1, 1'b0, MODE_SUMP, 200, 0, 0, 200);
      step();
      idle();
      reset = 1'b1;
      #1;
      check("rst_sump_vld", {31'd0, valid_output}, 32'd0);
      step();
      reset = 1'b0;
      step();
      expect_quiet("rst_sump_nopulse");
      drive(1'b1, 1'b1, MODE_SUMP, 2, 0, 0, 4);
      step();
      idle();
      expect_pulse("rst_sump_fresh", 8);
      step();

      // Trinomial after resets still correct.
      drive(1'b1, 1'b0, MODE_TRI, 5, 2, 1, 3);
      step();
      idle();
      step();
      expect_pulse("post_rst_tri", 52);
      step();
      expect_quiet("post_rst_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
